// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider that writes HI/LO for mfhi/mflo.
// Optional macro MULT_DIV_UNSIGNED_EN enables the op[1] unsigned variants (MULTU/DIVU).
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic               r_busy;
  logic               r_done;
  logic               r_div_zero;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_low;
  logic [WIDTH-1:0]   r_opb;

  logic               w_uns;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_b_zero;
  logic [WIDTH:0]     w_madd;
  logic [WIDTH:0]     w_shr;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;

`ifdef MULT_DIV_UNSIGNED_EN
  assign w_uns = op[1];
`else
  // op[1] has no effect in the signed-only build
  logic w_unused_op1;
  assign w_unused_op1 = op[1];
  assign w_uns = 1'b0;
`endif

  assign w_sa     = ~w_uns & a[WIDTH-1];
  assign w_sb     = ~w_uns & b[WIDTH-1];
  assign w_abs_a  = w_sa ? (~a + 1'b1) : a;
  assign w_abs_b  = w_sb ? (~b + 1'b1) : b;
  assign w_b_zero = (b == '0);

  // Multiply step: add multiplicand when the current multiplier bit is set, then shift right
  assign w_madd = {1'b0, r_acc} + (r_low[0] ? {1'b0, r_opb} : '0);

  // Divide step: remainder stays below the divisor, so W bits suffice after the subtract
  assign w_shr  = {r_acc, r_low[WIDTH-1]};
  assign w_ge   = (w_shr >= {1'b0, r_opb});
  assign w_diff = w_shr[WIDTH-1:0] - r_opb;

  assign w_prod   = {r_acc, r_low};
  assign w_prod_s = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_q      = r_neg_q ? (~r_low + 1'b1) : r_low;
  assign w_r      = r_neg_r ? (~r_acc + 1'b1) : r_acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_div      <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_dz       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_acc      <= '0;
      r_low      <= '0;
      r_opb      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_div      <= op[0];
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_div_zero <= 1'b0;
            r_acc      <= '0;
            r_neg_q    <= w_sa ^ w_sb;
            if (op[0]) begin
              r_neg_r <= w_sa;
              r_low   <= w_abs_a;
              r_opb   <= w_abs_b;
              r_dz    <= w_b_zero;
              r_state <= w_b_zero ? FIX : RUN;
            end else begin
              r_neg_r <= 1'b0;
              r_low   <= w_abs_b;
              r_opb   <= w_abs_a;
              r_dz    <= 1'b0;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (r_div) begin
            r_acc <= w_ge ? w_diff : w_shr[WIDTH-1:0];
            r_low <= {r_low[WIDTH-2:0], w_ge};
          end else begin
            r_acc <= w_madd[WIDTH:1];
            r_low <= {w_madd[0], r_low[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          if (r_dz) begin
            r_div_zero <= 1'b1;
          end else if (r_div) begin
            r_hi <= w_r;
            r_lo <= w_q;
          end else begin
            r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
            r_lo <= w_prod_s[WIDTH-1:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_div_zero;
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic/timing model checked every cycle plus hand-computed literals.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clock(clk), .reset(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: returns {hi, lo}
  function automatic logic [2*W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                                input logic [W-1:0] y);
    logic         uns;
    longint       sx, sy, sq, sr;
    logic [63:0]  p;
    logic [W-1:0] uq, ur;
`ifdef MULT_DIV_UNSIGNED_EN
    uns = o[1];
`else
    uns = 1'b0;
`endif
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    if (!o[0]) begin
      if (uns) p = {32'b0, x} * {32'b0, y};
      else     p = sx * sy;
      return p;
    end
    if (uns) begin
      uq = x / y;
      ur = x % y;
      return {ur, uq};
    end
    sq = sx / sy;
    sr = sx % sy;
    uq = sq[W-1:0];
    ur = sr[W-1:0];
    return {ur, uq};
  endfunction

  // Model: op latency in edges, result committed when it completes
  logic         m_busy, m_done, m_dz, p_dz;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  int           left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_hi = '0; m_lo = '0; left = 0;
      p_dz = 0; p_hi = '0; p_lo = '0;
    end else begin
      m_done = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          m_done = 1;
          m_busy = 0;
          if (p_dz) m_dz = 1;
          else begin m_hi = p_hi; m_lo = p_lo; end
        end
      end else if (start) begin
        m_busy = 1;
        m_dz   = 0;
        p_dz   = op[0] && (b == '0);
        if (!p_dz) {p_hi, p_lo} = ref_result(op, a, b);
        left = p_dz ? 1 : W + 1;
      end
    end
  end

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp("busy", 64'(busy), 64'(m_busy));
    cmp("done", 64'(done), 64'(m_done));
    cmp("div_zero", 64'(div_zero), 64'(m_dz));
    cmp("hi", 64'(hi), 64'(m_hi));
    cmp("lo", 64'(lo), 64'(m_lo));
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: done not seen within 40 cycles");
    end
  endtask

  int  cyc;
  bit  saw_done;

  initial begin
    repeat (2) tick();
    cmp("rst_hi", 64'(hi), 64'h0);
    rst = 1'b0;
    tick();

    // MULT 7 * -3
    issue(2'b00, 32'd7, 32'hFFFF_FFFD);
    cmp("mult_busy", 64'(busy), 64'h1);
    wait_done(cyc);
    cmp("mult_lat", 64'(cyc), 64'd33);
    cmp("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    cmp("mult_lo", 64'(lo), 64'hFFFF_FFEB);
    tick();
    cmp("mult_done_clr", 64'(done), 64'h0);

    // DIV -7 / 2, then most-negative / -1
    issue(2'b01, 32'hFFFF_FFF9, 32'd2);
    wait_done(cyc);
    cmp("div_lo", 64'(lo), 64'hFFFF_FFFD);
    cmp("div_hi", 64'(hi), 64'hFFFF_FFFF);
    cmp("div_dz", 64'(div_zero), 64'h0);
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(cyc);
    cmp("ovf_lo", 64'(lo), 64'h8000_0000);
    cmp("ovf_hi", 64'(hi), 64'h0);

    // Set hi=0x12 lo=0x34, then divide by zero
    issue(2'b01, 32'h3412, 32'h100);
    wait_done(cyc);
    cmp("pre_hi", 64'(hi), 64'h12);
    cmp("pre_lo", 64'(lo), 64'h34);
    tick();
    issue(2'b01, 32'd5, 32'd0);
    wait_done(cyc);
    cmp("dz_lat", 64'(cyc), 64'd1);
    cmp("dz_flag", 64'(div_zero), 64'h1);
    cmp("dz_hi", 64'(hi), 64'h12);
    cmp("dz_lo", 64'(lo), 64'h34);
    repeat (3) tick();
    cmp("dz_hold", 64'(div_zero), 64'h1);
    issue(2'b00, 32'd2, 32'd3);
    cmp("dz_clr", 64'(div_zero), 64'h0);
    wait_done(cyc);
    cmp("m23_lo", 64'(lo), 64'd6);
    cmp("m23_hi", 64'(hi), 64'd0);

    // Start while busy is ignored; back-to-back start in the done cycle
    tick();
    issue(2'b00, 32'd3, 32'd4);
    repeat (9) tick();
    start = 1'b1; a = 32'd9; b = 32'd9; op = 2'b00;
    tick();
    start = 1'b0;
    wait_done(cyc);
    cmp("ign_lat", 64'(cyc), 64'd23);
    cmp("ign_lo", 64'(lo), 64'd12);
    cmp("ign_hi", 64'(hi), 64'd0);
    issue(2'b00, 32'd5, 32'd6);
    wait_done(cyc);
    cmp("b2b_lat", 64'(cyc), 64'd33);
    cmp("b2b_lo", 64'(lo), 64'd30);

    // Async reset mid-RUN
    tick();
    issue(2'b00, 32'd7, 32'd7);
    repeat (14) tick();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("ar_busy", 64'(busy), 64'h0);
    cmp("ar_done", 64'(done), 64'h0);
    cmp("ar_hi", 64'(hi), 64'h0);
    cmp("ar_lo", 64'(lo), 64'h0);
    tick();
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) saw_done = 1;
    end
    cmp("ar_no_done", 64'(saw_done), 64'h0);

    // op[1] variants
    issue(2'b11, 32'hFFFF_FFFF, 32'h10);
    wait_done(cyc);
`ifdef MULT_DIV_UNSIGNED_EN
    cmp("divu_lo", 64'(lo), 64'h0FFF_FFFF);
    cmp("divu_hi", 64'(hi), 64'hF);
`else
    cmp("divu_lo", 64'(lo), 64'h0);
    cmp("divu_hi", 64'(hi), 64'hFFFF_FFFF);
`endif
    issue(2'b10, 32'hFFFF_FFFF, 32'd2);
    wait_done(cyc);
`ifdef MULT_DIV_UNSIGNED_EN
    cmp("multu_hi", 64'(hi), 64'h1);
`else
    cmp("multu_hi", 64'(hi), 64'hFFFF_FFFF);
`endif
    cmp("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    // A few extra signed mixes checked against the model only
    issue(2'b01, 32'd100, 32'hFFFF_FFF9);
    wait_done(cyc);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done(cyc);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
